// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run sequencer.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } run_state_t;

    localparam int RUN_CTRL_CNT_W = 16;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter: clr has priority, en advances, sticks at all-ones.
module sat_counter
    import run_ctrl_pkg::*;
#(
    parameter int W = RUN_CTRL_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer for the 9-bit-instruction core: start/done handshake, core reset, run enable.
// Optional watchdog enabled by defining RUN_CTRL_WDOG_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int           D        = 12,
    parameter int           C        = RUN_CTRL_CNT_W,
    parameter int           INIT_CYC = 2,
    parameter logic [D-1:0] PC_END   = 12'hFFF
`ifdef RUN_CTRL_WDOG_EN
   ,parameter logic [C-1:0] WDOG_LIMIT = 16'hFFF0
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         halt,
    input  logic [D-1:0] prog_ctr,
    output logic         core_rst,
    output logic         core_en,
    output logic         done,
    output logic         busy,
    output logic [C-1:0] cycle_cnt,
    output logic         timeout
);

    localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

    run_state_t    state;
    run_state_t    next_state;
    logic [IW-1:0] init_cnt;
    logic          run_end;
    logic          wdog_hit;
    logic          start;

    assign run_end = halt || (prog_ctr == PC_END);
    assign start   = (state == IDLE) && req;

`ifdef RUN_CTRL_WDOG_EN
    assign wdog_hit = (cycle_cnt == WDOG_LIMIT - 1'b1);

    // Sticky until the next run starts so the host can read it after done drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else if (start) begin
            timeout <= 1'b0;
        end else if ((state == RUN) && req && !run_end && wdog_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt <= '0;
        end else if (start) begin
            init_cnt <= IW'(INIT_CYC - 1);
        end else if ((state == INIT) && (init_cnt != '0)) begin
            init_cnt <= init_cnt - 1'b1;
        end
    end

    // Abort outranks completion, which outranks the watchdog.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (req) next_state = INIT;
            INIT: begin
                if (!req)                 next_state = IDLE;
                else if (init_cnt == '0)  next_state = RUN;
            end
            RUN: begin
                if (!req)                 next_state = IDLE;
                else if (run_end)         next_state = DONE;
                else if (wdog_hit)        next_state = DONE;
            end
            DONE: if (!req) next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    always_comb begin
        core_rst = 1'b1;
        core_en  = 1'b0;
        done     = 1'b0;
        busy     = 1'b0;
        unique case (state)
            IDLE: core_rst = 1'b1;
            INIT: busy     = 1'b1;
            RUN: begin
                core_rst = 1'b0;
                core_en  = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            default: core_rst = 1'b1;
        endcase
    end

    sat_counter #(
        .W (C)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (state == RUN),
        .cnt   (cycle_cnt)
    );

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed handshake scenarios plus a randomized phase against a behavioural model.
module tb_run_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        halt;
    logic [11:0] prog_ctr;
    logic        core_rst;
    logic        core_en;
    logic        done;
    logic        busy;
    logic [15:0] cycle_cnt;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

`ifdef RUN_CTRL_WDOG_EN
    localparam bit WDOG_ON    = 1'b1;
    localparam int WDOG_LIMIT = 8;
`else
    localparam bit WDOG_ON    = 1'b0;
    localparam int WDOG_LIMIT = 65536;
`endif
    localparam int INIT_CYC = 2;

    run_ctrl #(
        .INIT_CYC (INIT_CYC)
`ifdef RUN_CTRL_WDOG_EN
       ,.WDOG_LIMIT (16'(WDOG_LIMIT))
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .halt      (halt),
        .prog_ctr  (prog_ctr),
        .core_rst  (core_rst),
        .core_en   (core_en),
        .done      (done),
        .busy      (busy),
        .cycle_cnt (cycle_cnt),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what the host should see, tracked as plain flags and counts.
    bit m_initing;
    bit m_running;
    bit m_done;
    bit m_timeout;
    int m_init_left;
    int m_count;

    task automatic model_reset();
        m_initing   = 1'b0;
        m_running   = 1'b0;
        m_done      = 1'b0;
        m_timeout   = 1'b0;
        m_init_left = 0;
        m_count     = 0;
    endtask

    task automatic model_step(input bit r, input bit h, input logic [11:0] p);
        if (m_done) begin
            if (!r) m_done = 1'b0;
        end else if (m_running) begin
            if (m_count < 65535) m_count++;
            if (!r) begin
                m_running = 1'b0;
            end else if (h || (p == 12'hFFF)) begin
                m_running = 1'b0;
                m_done    = 1'b1;
            end else if (WDOG_ON && (m_count == WDOG_LIMIT)) begin
                m_running = 1'b0;
                m_done    = 1'b1;
                m_timeout = 1'b1;
            end
        end else if (m_initing) begin
            if (!r) begin
                m_initing = 1'b0;
            end else if (m_init_left == 1) begin
                m_initing = 1'b0;
                m_running = 1'b1;
            end else begin
                m_init_left--;
            end
        end else if (r) begin
            m_initing   = 1'b1;
            m_init_left = INIT_CYC;
            m_count     = 0;
            m_timeout   = 1'b0;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".core_rst"},  32'(core_rst),  32'(!(m_running || m_done)));
        check_output({tag, ".core_en"},   32'(core_en),   32'(m_running));
        check_output({tag, ".done"},      32'(done),      32'(m_done));
        check_output({tag, ".busy"},      32'(busy),      32'(m_initing || m_running));
        check_output({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(m_count));
        check_output({tag, ".timeout"},   32'(timeout),   32'(m_timeout));
    endtask

    task automatic apply_stimulus(input string tag, input bit r, input bit h, input logic [11:0] p);
        req      = r;
        halt     = h;
        prog_ctr = p;
        @(posedge clk);
        model_step(r, h, p);
        #1;
        check_all(tag);
    endtask

    function automatic logic [11:0] safe_pc();
        return 12'($urandom_range(0, 12'hFFE));
    endfunction

    initial begin
        bit          r;
        bit          h;
        logic [11:0] p;

        reset    = 1'b0;
        req      = 1'b0;
        halt     = 1'b0;
        prog_ctr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        for (int i = 0; i < 10; i++) apply_stimulus("idle", 1'b0, 1'b0, safe_pc());

        // Normal run ended by halt in the 5th RUN cycle.
        apply_stimulus("n_init0", 1'b1, 1'b0, safe_pc());
        apply_stimulus("n_init1", 1'b1, 1'b0, safe_pc());
        check_output("n_init_rst", 32'(core_rst), 32'd1);
        apply_stimulus("n_run0", 1'b1, 1'b0, safe_pc());
        check_output("n_run_en", 32'(core_en), 32'd1);
        for (int i = 0; i < 4; i++) apply_stimulus("n_run", 1'b1, 1'b0, safe_pc());
        apply_stimulus("n_halt", 1'b1, 1'b1, safe_pc());
        check_output("n_halt_done", 32'(done), 32'd1);
        check_output("n_halt_cnt", 32'(cycle_cnt), 32'd5);
        apply_stimulus("n_drop", 1'b0, 1'b0, safe_pc());
        check_output("n_drop_done", 32'(done), 32'd0);

        // Completion from PC reaching the end address on the 7th RUN cycle.
        for (int i = 0; i < 3; i++) apply_stimulus("p_start", 1'b1, 1'b0, safe_pc());
        for (int i = 0; i < 6; i++) apply_stimulus("p_run", 1'b1, 1'b0, safe_pc());
        apply_stimulus("p_end", 1'b1, 1'b0, 12'hFFF);
        check_output("p_end_done", 32'(done), 32'd1);
        check_output("p_end_cnt", 32'(cycle_cnt), 32'd7);
        check_output("p_end_tmo", 32'(timeout), 32'd0);

        // Held request must not restart; a fresh rising edge does.
        for (int i = 0; i < 20; i++) apply_stimulus("rearm_hold", 1'b1, 1'b0, safe_pc());
        check_output("rearm_busy", 32'(busy), 32'd0);
        apply_stimulus("rearm_low", 1'b0, 1'b0, safe_pc());
        apply_stimulus("rearm_init", 1'b1, 1'b0, safe_pc());
        check_output("rearm_cnt", 32'(cycle_cnt), 32'd0);
        check_output("rearm_busy2", 32'(busy), 32'd1);

        // Abort on the 3rd RUN cycle with halt also high: abort wins.
        apply_stimulus("a_init1", 1'b1, 1'b0, safe_pc());
        apply_stimulus("a_run0", 1'b1, 1'b0, safe_pc());
        for (int i = 0; i < 2; i++) apply_stimulus("a_run", 1'b1, 1'b0, safe_pc());
        apply_stimulus("a_abort", 1'b0, 1'b1, safe_pc());
        check_output("a_done", 32'(done), 32'd0);
        check_output("a_cnt", 32'(cycle_cnt), 32'd3);
        check_output("a_busy", 32'(busy), 32'd0);

        // Long run with no halt: watchdog ends it if present, otherwise it keeps going.
        for (int i = 0; i < 3; i++) apply_stimulus("w_start", 1'b1, 1'b0, safe_pc());
        for (int i = 0; i < 100; i++) apply_stimulus("w_run", 1'b1, 1'b0, safe_pc());
`ifdef RUN_CTRL_WDOG_EN
        check_output("w_done", 32'(done), 32'd1);
        check_output("w_tmo", 32'(timeout), 32'd1);
        check_output("w_cnt", 32'(cycle_cnt), 32'd8);
`else
        check_output("w_busy", 32'(busy), 32'd1);
        check_output("w_tmo", 32'(timeout), 32'd0);
        check_output("w_cnt", 32'(cycle_cnt), 32'd100);
`endif
        apply_stimulus("w_drop", 1'b0, 1'b0, safe_pc());

        // Asynchronous reset in the middle of a run.
        for (int i = 0; i < 6; i++) apply_stimulus("r_run", 1'b1, 1'b0, safe_pc());
        #3;
        reset = 1'b0;
        req   = 1'b0;
        model_reset();
        #1;
        check_all("midreset");
        #12;
        reset = 1'b1;
        apply_stimulus("r_after", 1'b0, 1'b0, safe_pc());

        // Randomized traffic against the model.
        r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) r = ~r;
            h = ($urandom_range(0, 15) == 0);
            p = ($urandom_range(0, 31) == 0) ? 12'hFFF : safe_pc();
            apply_stimulus("rand", r, h, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run sequencer for the 9-bit-instruction core: owns the core's start/done handshake, holds the datapath in reset during initialisation, and gates execution.
- Detects program completion, either from the halt decode or from the PC reaching a fixed end address, then reports done.
- Counts execution cycles for benchmarking.
- Sits between the testbench/host `req`/`done` pins and the core's `reset` and run-enable inputs.

Parameters:
- D, 12, program counter width (matches PC).
- C, 16, cycle counter width.
- INIT_CYC, 2, cycles core_rst is held in INIT (≥1).
- PC_END, 12'hFFF, PC value treated as end-of-program.
- WDOG_LIMIT, 16'hFFF0, run-cycle limit (used only with watchdog).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  1  host start request; level, 4-phase handshake.
- halt  in  1  decoder: halt instruction in current cycle.
- prog_ctr  in  D  current PC from core.
- core_rst  out  1  active-high reset to core PC/reg file.
- core_en  out  1  core run enable (PC advance, RegWrite/MemWrite qualify).
- done  out  1  run complete; held until req drops.
- busy  out  1  high in INIT or RUN.
- cycle_cnt  out  C  RUN cycles of last/current run.
- timeout  out  1  last run ended by watchdog.

Behaviour:
- Async reset (reset=0):
  - state=IDLE, core_rst=1, core_en=0, done=0, busy=0, cycle_cnt=0, timeout=0.
  - Release is synchronous to clk in effect: the FSM first acts on the first rising edge with reset=1.
- States, 2-bit: IDLE, INIT, RUN, DONE. All outputs are registered or decoded from registered state; no combinational path from req or halt to any output.
- IDLE: core_rst=1, core_en=0.
  - req=1 → INIT; clear cycle_cnt, clear timeout, load init counter with INIT_CYC-1.
- INIT: core_rst=1, busy=1.
  - Init counter decrements each cycle; at 0 → RUN. Exactly INIT_CYC cycles are spent in INIT.
- RUN: core_rst=0, core_en=1, busy=1.
  - cycle_cnt += 1 every RUN cycle, including the exit cycle; saturates at all-ones, no wrap.
  - halt=1 or prog_ctr==PC_END → DONE at next edge.
- DONE: done=1, core_en=0, core_rst=0, so core state stays observable; cycle_cnt and timeout frozen.
  - req=0 → IDLE; done drops the cycle after req falls.
- Abort: req=0 during INIT or RUN → IDLE next edge. done is never asserted; cycle_cnt keeps the partial count.
- Priority in RUN: abort (req=0) > completion (halt/PC_END) > watchdog.
- req held at 1 after DONE does not restart; a new run needs req 0→1 through IDLE.
- Async reset mid-run forces the reset values immediately; any run in progress is lost.

Optional Feature:
- Macro: RUN_CTRL_WDOG_EN.
- Defined:
  - In RUN, if cycle_cnt == WDOG_LIMIT-1 at an edge with no halt, no PC_END and req=1 → DONE with timeout=1.
  - Final cycle_cnt is WDOG_LIMIT.
  - timeout is cleared on entry to INIT.
- Undefined: no watchdog logic; timeout tied 0; a run lasts until halt, PC_END or abort.

Decomposition:
- Package run_ctrl_pkg:
  - typedef enum logic[1:0] run_state_t {IDLE, INIT, RUN, DONE};
  - constant for the default cycle-count width.
- One sub-module: sat_counter, parameterized width W, with inputs clr, en and output cnt; saturating increment. Used for cycle_cnt.
- The init down-counter stays inline.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, then release with req=0 → core_rst=1, core_en=0, done=0, cycle_cnt=0 for 10 cycles.
- Normal run, INIT_CYC=2:
  - req↑ at cycle 0 → core_rst=1 through cycles 1-2, core_en=1 from cycle 3.
  - halt pulsed in the 5th RUN cycle → done=1 the next cycle, cycle_cnt=5.
  - req↓ → done=0 one cycle later, state IDLE.
- PC end: drive prog_ctr=12'hFFF on the 7th RUN cycle → done=1, cycle_cnt=7, timeout=0.
- Abort: req↓ on the 3rd RUN cycle with halt=1 in the same cycle → IDLE, done never 1, cycle_cnt=3.
- Re-arm: keep req=1 for 20 cycles after done → no new INIT. Then req 0→1 → INIT, cycle_cnt cleared to 0.
- Watchdog, with RUN_CTRL_WDOG_EN, WDOG_LIMIT=8, no halt → done=1, timeout=1, cycle_cnt=8. Same stimulus without the macro → still busy after 100 cycles, timeout=0.
